// File: rtl/loadstore.sv
// Load/store pipeline stage: turns execute-stage memory ops into single pipelined Wishbone B4
// transactions, steering store lanes and extracting/extending load data.
module loadstore #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        input_valid_i,
    output logic        input_ready_o,
    input  logic        mem_enable_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic [31:0] result_i,
    input  logic        reg_write_i,
    input  logic [4:0]  reg_addr_i,
    output logic        output_valid_o,
    output logic        reg_write_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_data_o,
    output logic        misaligned_o,
    output logic        bus_error_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {StIdle, StRequest, StWaitAck, StDone} state_t;

    localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_timeout;
    logic        r_cyc, r_stb, r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr, r_dat;
    logic [1:0]  r_lane, r_size;
    logic        r_unsigned, r_rd_we;
    logic [4:0]  r_rd_addr;
    logic        r_valid, r_reg_write, r_misaligned, r_bus_error;
    logic [4:0]  r_reg_addr;
    logic [31:0] r_reg_data;

    logic        w_accept, w_misaligned, w_ack_take, w_timeout;
    logic [3:0]  w_sel;
    logic [31:0] w_dat, w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign input_ready_o = (r_state == StIdle);
    assign w_accept      = input_valid_i & input_ready_o;
    assign w_ack_take    = wb_ack_i & (((r_state == StRequest) & ~wb_stall_i)
                                       | (r_state == StWaitAck));
    assign w_timeout     = (r_state == StWaitAck) & ~wb_ack_i & (r_timeout == TimeoutLast);

    always_comb begin
        w_misaligned = 1'b0;
        w_sel        = 4'b1111;
        w_dat        = mem_data_i;
        case (mem_size_i)
            2'b00: begin
                w_sel = 4'b0001 << mem_addr_i[1:0];
                w_dat = {4{mem_data_i[7:0]}};
            end
            2'b01: begin
                w_misaligned = mem_addr_i[0];
                w_sel        = 4'b0011 << mem_addr_i[1:0];
                w_dat        = {2{mem_data_i[15:0]}};
            end
            default: w_misaligned = |mem_addr_i[1:0];
        endcase
        // Loads read the whole word and extract the lane on return.
        if (!mem_we_i) begin
            w_sel = 4'b1111;
            w_dat = '0;
        end
    end

    always_comb begin
        w_byte = wb_dat_i[7:0];
        case (r_lane)
            2'd0: w_byte = wb_dat_i[7:0];
            2'd1: w_byte = wb_dat_i[15:8];
            2'd2: w_byte = wb_dat_i[23:16];
            default: w_byte = wb_dat_i[31:24];
        endcase
        w_half = r_lane[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];
        case (r_size)
            2'b00:   w_load_data = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
            2'b01:   w_load_data = {{16{w_half[15] & ~r_unsigned}}, w_half};
            default: w_load_data = wb_dat_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_timeout    <= '0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_adr        <= '0;
            r_dat        <= '0;
            r_lane       <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_rd_we      <= 1'b0;
            r_rd_addr    <= '0;
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            r_reg_addr   <= '0;
            r_reg_data   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (!mem_enable_i) begin
                            r_state     <= StDone;
                            r_valid     <= 1'b1;
                            r_reg_write <= reg_write_i;
                            r_reg_addr  <= reg_addr_i;
                            r_reg_data  <= result_i;
                        end else if (w_misaligned) begin
                            r_state      <= StDone;
                            r_valid      <= 1'b1;
                            r_misaligned <= 1'b1;
                            r_reg_write  <= 1'b0;
                            r_reg_addr   <= reg_addr_i;
                            r_reg_data   <= '0;
                        end else begin
                            r_state    <= StRequest;
                            r_cyc      <= 1'b1;
                            r_stb      <= 1'b1;
                            r_we       <= mem_we_i;
                            r_sel      <= w_sel;
                            r_dat      <= w_dat;
                            r_adr      <= {mem_addr_i[31:2], 2'b00};
                            r_lane     <= mem_addr_i[1:0];
                            r_size     <= mem_size_i;
                            r_unsigned <= mem_unsigned_i;
                            r_rd_we    <= reg_write_i;
                            r_rd_addr  <= reg_addr_i;
                        end
                    end
                end
                StRequest: begin
                    if (!wb_stall_i) begin
                        r_stb     <= 1'b0;
                        r_timeout <= '0;
                        r_state   <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (w_timeout) begin
                        r_state     <= StDone;
                        r_cyc       <= 1'b0;
                        r_valid     <= 1'b1;
                        r_bus_error <= 1'b1;
                        r_reg_write <= 1'b0;
                        r_reg_addr  <= r_rd_addr;
                        r_reg_data  <= '0;
                    end else begin
                        r_timeout <= r_timeout + 8'd1;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_valid      <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_bus_error  <= 1'b0;
                    r_reg_write  <= 1'b0;
                    r_reg_addr   <= '0;
                    r_reg_data   <= '0;
                end
            endcase
            // Ack completion overrides the REQUEST/WAIT_ACK transitions above.
            if (w_ack_take) begin
                r_state     <= StDone;
                r_cyc       <= 1'b0;
                r_stb       <= 1'b0;
                r_valid     <= 1'b1;
                r_reg_write <= r_rd_we & ~r_we;
                r_reg_addr  <= r_rd_addr;
                r_reg_data  <= r_we ? 32'd0 : w_load_data;
            end
        end
    end

    assign output_valid_o = r_valid;
    assign reg_write_o    = r_reg_write;
    assign reg_addr_o     = r_reg_addr;
    assign reg_data_o     = r_reg_data;
    assign misaligned_o   = r_misaligned;
    assign bus_error_o    = r_bus_error;
    assign wb_adr_o       = r_adr;
    assign wb_dat_o       = r_dat;
    assign wb_we_o        = r_we;
    assign wb_sel_o       = r_sel;
    assign wb_stb_o       = r_stb;
    assign wb_cyc_o       = r_cyc;

endmodule

// File: tb/tb_loadstore.sv
// Randomised scoreboard bench for loadstore: a byte-level memory model predicts writeback
// results and bus requests; a Wishbone slave model and an output monitor check them.
module tb_loadstore;

    localparam int unsigned AckTo = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        input_valid_i = 1'b0;
    logic        input_ready_o;
    logic        mem_enable_i = 1'b0, mem_we_i = 1'b0, mem_unsigned_i = 1'b0;
    logic [1:0]  mem_size_i = '0;
    logic [31:0] mem_addr_i = '0, mem_data_i = '0, result_i = '0;
    logic        reg_write_i = 1'b0;
    logic [4:0]  reg_addr_i = '0;
    logic        output_valid_o, reg_write_o, misaligned_o, bus_error_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_o, wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i = 1'b0, wb_stall_i = 1'b0;

    loadstore #(.ACK_TIMEOUT(AckTo)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
        .mem_enable_i(mem_enable_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .result_i(result_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
        .output_valid_o(output_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
        .reg_data_o(reg_data_o), .misaligned_o(misaligned_o), .bus_error_o(bus_error_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o),
        .wb_stall_i(wb_stall_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] rd;
        logic        mis;
        logic        berr;
    } exp_t;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } breq_t;

    exp_t        exp_q[$];
    breq_t       breq_q[$];
    logic [31:0] model_mem[16];
    logic [31:0] bus_mem[16];
    int          checks = 0;
    int          failures = 0;
    int          cfg_stall = 0, cfg_lat = 0;
    int          waitcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Output monitor
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && output_valid_o) begin
            if (prev_valid) chk("valid_pulse_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("reg_write", {31'd0, reg_write_o}, {31'd0, e.rw});
                chk("misaligned", {31'd0, misaligned_o}, {31'd0, e.mis});
                chk("bus_error", {31'd0, bus_error_o}, {31'd0, e.berr});
                chk("reg_data", reg_data_o, e.rd);
                if (e.rw) chk("reg_addr", {27'd0, reg_addr_o}, {27'd0, e.ra});
            end
        end
        prev_valid = output_valid_o;
    end

    // Wishbone slave model, drives away from the active edge
    int          stb_cnt = 0, ack_delay = 0;
    bit          pending = 0;
    logic [31:0] rdata;
    always @(negedge clk) begin
        breq_t b;
        int    idx;
        wb_ack_i   = 1'b0;
        wb_stall_i = 1'b0;
        wb_dat_i   = $urandom();
        if (wb_cyc_o && !wb_stb_o) waitcnt++;
        if (pending) begin
            if (ack_delay == 0) begin
                wb_ack_i = 1'b1;
                wb_dat_i = rdata;
                pending  = 0;
            end else begin
                ack_delay--;
            end
        end else if (wb_cyc_o && wb_stb_o) begin
            stb_cnt++;
            if (stb_cnt <= cfg_stall) begin
                wb_stall_i = 1'b1;
            end else begin
                stb_cnt = 0;
                if (breq_q.size() == 0) begin
                    chk("unexpected_stb", 32'd1, 32'd0);
                end else begin
                    b = breq_q.pop_front();
                    chk("wb_adr", wb_adr_o, b.adr);
                    chk("wb_we", {31'd0, wb_we_o}, {31'd0, b.we});
                    chk("wb_sel", {28'd0, wb_sel_o}, {28'd0, b.sel});
                    if (b.we) chk("wb_dat", wb_dat_o, b.dat);
                end
                idx = int'(wb_adr_o[5:2]);
                if (wb_we_o && cfg_lat <= int'(AckTo))
                    for (int k = 0; k < 4; k++)
                        if (wb_sel_o[k]) bus_mem[idx][8*k +: 8] = wb_dat_o[8*k +: 8];
                rdata = bus_mem[idx];
                if (cfg_lat == 0) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = rdata;
                end else begin
                    pending   = 1;
                    ack_delay = cfg_lat - 1;
                end
            end
        end
        if (!wb_stb_o) stb_cnt = 0;
    end

    task automatic wait_ready(input string name);
        int g = 0;
        while (!input_ready_o && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (!input_ready_o) fail_now(name);
    endtask

    // Issue one instruction (called at a negedge) and predict its effects.
    task automatic run_txn(input logic mem, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] res, input logic rw, input logic [4:0] ra,
                           input int stall, input int lat);
        exp_t        e;
        breq_t       b;
        int          nb, lane, idx;
        logic [31:0] v;
        bit          mis;
        nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        lane = int'(addr[1:0]);
        idx  = int'(addr[5:2]);
        mis  = mem && (lane % nb != 0);
        e    = '{rw: 1'b0, ra: ra, rd: 32'd0, mis: 1'b0, berr: 1'b0};
        if (!mem) begin
            e.rw = rw;
            e.rd = res;
        end else if (mis) begin
            e.mis = 1'b1;
        end else begin
            b.adr = addr & 32'hFFFF_FFFC;
            b.we  = we;
            b.sel = we ? 4'b0000 : 4'b1111;
            b.dat = '0;
            if (we) begin
                for (int k = 0; k < nb; k++) b.sel[lane + k] = 1'b1;
                for (int k = 0; k < 4; k++) b.dat[8*k +: 8] = data[8*(k % nb) +: 8];
            end
            breq_q.push_back(b);
            if (lat > int'(AckTo)) begin
                e.berr = 1'b1;
            end else if (we) begin
                for (int k = 0; k < nb; k++) model_mem[idx][8*(lane + k) +: 8] = data[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < nb; k++) v[8*k +: 8] = model_mem[idx][8*(lane + k) +: 8];
                if (!uns && nb < 4 && v[8*nb - 1])
                    for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
                e.rw = rw;
                e.rd = v;
            end
        end
        wait_ready("ready_before_issue");
        cfg_stall = stall;
        cfg_lat   = lat;
        waitcnt   = 0;
        exp_q.push_back(e);
        mem_enable_i = mem; mem_we_i = we; mem_size_i = size; mem_unsigned_i = uns;
        mem_addr_i = addr; mem_data_i = data; result_i = res;
        reg_write_i = rw; reg_addr_i = ra;
        input_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_valid_i = 1'b0;
        mem_enable_i = $urandom();
        result_i = $urandom();
        if (!mem || mis) begin
            chk("latency1_valid", {31'd0, output_valid_o}, 32'd1);
            chk("no_bus_cyc", {31'd0, wb_cyc_o}, 32'd0);
        end
        wait_ready("ready_after_txn");
        if (mem && !mis)
            chk("wait_ack_cycles", waitcnt, (lat > int'(AckTo)) ? AckTo : lat);
    endtask

    initial begin
        int vcount;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = $urandom();
            bus_mem[i]   = model_mem[i];
        end
        model_mem[0] = 32'h80FF_FFFF;
        bus_mem[0]   = 32'h80FF_FFFF;

        #2;
        chk("rst_ready", {31'd0, input_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, output_valid_o}, 32'd0);
        chk("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("rst_sel_adr", wb_adr_o | {28'd0, wb_sel_o}, 32'd0);
        chk("rst_reg_data", reg_data_o, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h1234, 1'b1, 5'd5, 0, 0);
        run_txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h0, 1'b1, 5'd7, 0, 1);
        run_txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h0, 1'b1, 5'd8, 0, 1);
        run_txn(1'b1, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h0, 1'b1, 5'd9, 3, 1);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 32'h0, 1'b1, 5'd10, 0, 0);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 5'd11, 0, 5);
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h4004, 32'h0, 32'h0, 1'b1, 5'd12, 1, int'(AckTo));
        run_txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd13, 0, 0);

        // Reset while waiting for ack; the ack then arrives after release
        wait_ready("ready_before_reset_test");
        breq_q.push_back('{adr: 32'h5008, we: 1'b0, sel: 4'b1111, dat: 32'd0});
        cfg_stall = 0;
        cfg_lat   = 6;
        mem_enable_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = 32'h5008;
        reg_write_i = 1'b1; reg_addr_i = 5'd3;
        input_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        input_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_reset_wait_ack", {30'd0, wb_cyc_o, wb_stb_o}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("reset_ready", {31'd0, input_ready_o}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (output_valid_o) vcount++;
        end
        chk("no_valid_after_reset", vcount, 0);

        // Randomised traffic
        for (int n = 0; n < 120; n++) begin
            logic        mem, we, uns, rw;
            logic [1:0]  size;
            logic [31:0] addr;
            int          lat;
            mem  = ($urandom_range(0, 3) != 0);
            we   = $urandom();
            size = 2'($urandom_range(0, 3));
            uns  = $urandom();
            rw   = ($urandom_range(0, 4) != 0);
            addr = {$urandom() >> 6, 4'($urandom()), 2'($urandom())} ;
            addr = {addr[31:6], addr[5:0]};
            lat  = $urandom_range(0, int'(AckTo));
            if (!we && $urandom_range(0, 9) == 0) lat = int'(AckTo) + $urandom_range(1, 2);
            run_txn(mem, we, size, uns, addr, $urandom(), $urandom(), rw,
                    5'($urandom()), $urandom_range(0, 3), lat);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + breq_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/loadstore.md
Name: loadstore

Overview:
- Load/store stage of the ECAP5-DPROC pipeline, between execute and writeback.
- Turns execute-stage memory operations into single pipelined Wishbone B4 master transactions. Its bus port connects to the data slave port of the external memory manager.
- Performs byte-lane steering for stores and lane extraction with sign/zero extension for loads.
- Passes non-memory results through to writeback with one cycle of latency.

Parameters:
ACK_TIMEOUT, 255, max cycles spent in WAIT_ACK before the transaction is aborted with a bus error (must be ≥1; 8-bit counter).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
input_valid_i  in  1  execute stage presents an instruction
input_ready_o  out  1  stage can accept an instruction
mem_enable_i  in  1  instruction is a load/store
mem_we_i  in  1  1=store, 0=load
mem_size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
mem_unsigned_i  in  1  zero-extend load result
mem_addr_i  in  32  byte address
mem_data_i  in  32  store data (right-aligned)
result_i  in  32  ALU result for non-memory instructions
reg_write_i  in  1  instruction writes rd
reg_addr_i  in  5  rd index
output_valid_o  out  1  one-cycle pulse, result for writeback
reg_write_o  out  1  write enable to register file
reg_addr_o  out  5  rd index
reg_data_o  out  32  write data
misaligned_o  out  1  pulse with output_valid_o: access was misaligned, no bus cycle
bus_error_o  out  1  pulse with output_valid_o: ack timeout
wb_adr_o  out  32  word-aligned address ({addr[31:2],2'b00})
wb_dat_o  out  32  store data
wb_dat_i  in  32  load data
wb_we_o  out  1  write enable
wb_sel_o  out  4  byte lanes
wb_stb_o  out  1  strobe
wb_ack_i  in  1  acknowledge
wb_cyc_o  out  1  cycle
wb_stall_i  in  1  stall

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE.
  - All outputs 0 except input_ready_o=1.
  - A transaction in progress is dropped, cyc/stb fall immediately, and no output pulse follows reset release.
- States: IDLE, REQUEST, WAIT_ACK, DONE.
- input_ready_o = (state==IDLE). Accept occurs when input_valid_i & input_ready_o at a rising edge.
- IDLE, on accept:
  - Non-memory instruction: register result_i/reg_*; go to DONE. output_valid_o is high the next cycle (latency 1).
  - Misaligned memory op (half with addr[0]=1; word with addr[1:0]≠0): go to DONE with misaligned_o=1 and reg_write_o=0. No bus activity.
  - Aligned memory op: latch the request and go to REQUEST.
- REQUEST:
  - cyc_o=1, stb_o=1; adr/we/sel/dat stay stable.
  - If wb_stall_i=0 at the edge, the request is accepted:
    - If wb_ack_i is also 1, capture data and go to DONE.
    - Otherwise go to WAIT_ACK.
  - While stalled, remain in REQUEST with stb held high.
- WAIT_ACK:
  - cyc_o=1, stb_o=0; timeout counter increments each cycle.
  - On wb_ack_i=1: capture wb_dat_i, go to DONE.
  - If the counter reaches ACK_TIMEOUT without ack: drop cyc, go to DONE with bus_error_o=1 and reg_write_o=0.
- DONE:
  - output_valid_o=1 for exactly one cycle; cyc_o=0.
  - Go to IDLE. No accept in DONE, so back-to-back throughput is 1 instruction every 2 cycles for non-memory instructions.
- Store lane steering:
  - Byte: sel=0001<<addr[1:0], dat={4{d[7:0]}}.
  - Half: sel=0011<<addr[1:0], dat={2{d[15:0]}}.
  - Word: sel=1111, dat=d.
- Load extraction:
  - Byte = wb_dat_i[8*addr[1:0]+:8]; half = wb_dat_i[16*addr[1]+:16].
  - Sign-extend unless mem_unsigned_i. Word passes through unchanged.
- Stores: reg_write_o forced 0; reg_data_o=0.
- A late ack in IDLE or DONE is ignored.

Test Plan:
1. Non-memory: result_i=0x1234, reg_write_i=1, rd=5 -> output_valid_o one cycle after accept, reg_data_o=0x1234, reg_addr_o=5, no cyc.
2. Signed load byte at 0x1003, bus returns 0x80FFFFFF one cycle after stb (no stall) -> adr=0x1000, sel=1111, reg_data_o=0xFFFFFF80; with mem_unsigned_i=1 -> 0x00000080.
3. Store half 0xABCD at 0x2002 with wb_stall_i high for 3 cycles -> stb held 4 cycles, sel=1100, dat=0xABCDABCD, we=1, then output_valid_o with reg_write_o=0.
4. Word load at 0x3001 -> no cyc/stb ever, output_valid_o with misaligned_o=1, reg_write_o=0.
5. ACK_TIMEOUT=4, no ack -> cyc drops after 4 WAIT_ACK cycles, bus_error_o=1; next instruction accepted normally.
6. Assert rst_ni=0 during WAIT_ACK -> cyc_o/stb_o 0 immediately, input_ready_o=1; a subsequent ack produces no output_valid_o.
